// File: rtl/bitrev_spi_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bitrev_spi_ctrl_if : requester handshakes and SPI pins of bitrev_spi_ctrl    |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
interface bitrev_spi_ctrl_if;
  logic       req0_valid;
  logic       req1_valid;
  logic [7:0] req0_data;
  logic [7:0] req1_data;
  logic       req0_ready;
  logic       req1_ready;
  logic       rsp0_valid;
  logic       rsp1_valid;
  logic [7:0] rsp0_data;
  logic [7:0] rsp1_data;
  logic       busy;
  logic       spi_sck;
  logic       spi_ss;
  logic       spi_mosi;
  logic       spi_miso;

  modport slave (
    input  req0_valid, req1_valid, req0_data, req1_data, spi_miso,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
           rsp0_data, rsp1_data, busy, spi_sck, spi_ss, spi_mosi
  );

  modport master (
    output req0_valid, req1_valid, req0_data, req1_data, spi_miso,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
           rsp0_data, rsp1_data, busy, spi_sck, spi_ss, spi_mosi
  );
endinterface
`default_nettype wire

// File: rtl/bitrev_spi_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bitrev_spi_ctrl : two-port round-robin SPI master for the bit-reverse device |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module bitrev_spi_ctrl #(
  parameter int CLK_DIV = 2,
  parameter int SS_GAP  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  bitrev_spi_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_DONE  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  localparam logic [7:0] c_div_last = 8'(CLK_DIV - 1);
  localparam logic [7:0] c_gap_last = 8'(SS_GAP - 1);

  state_t     r_state;
  logic [7:0] r_div;
  logic [7:0] r_gap;
  logic [7:0] r_tx;
  logic [7:0] r_rx;
  logic [7:0] r_rsp0_data;
  logic [7:0] r_rsp1_data;
  logic [4:0] r_edge;
  logic       r_owner;
  logic       r_last;
  logic       r_sck;
  logic       r_ss;
  logic       r_mosi;
  logic       r_rsp0_valid;
  logic       r_rsp1_valid;

  logic       w_grant;
  logic       w_accept;
  logic       w_div_tc;
  logic [7:0] w_req_data;

  // With both or neither requesting, the port not served last wins.
  always_comb begin
    w_grant = ~r_last;
    if (bus.req0_valid && !bus.req1_valid) begin
      w_grant = 1'b0;
    end else if (!bus.req0_valid && bus.req1_valid) begin
      w_grant = 1'b1;
    end
    w_accept   = (r_state == S_IDLE) && (w_grant ? bus.req1_valid : bus.req0_valid);
    w_req_data = w_grant ? bus.req1_data : bus.req0_data;
  end

  assign w_div_tc       = (r_div == c_div_last);
  assign bus.req0_ready = (r_state == S_IDLE) && !w_grant;
  assign bus.req1_ready = (r_state == S_IDLE) && w_grant;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.spi_sck    = r_sck;
  assign bus.spi_ss     = r_ss;
  assign bus.spi_mosi   = r_mosi;
  assign bus.rsp0_valid = r_rsp0_valid;
  assign bus.rsp1_valid = r_rsp1_valid;
  assign bus.rsp0_data  = r_rsp0_data;
  assign bus.rsp1_data  = r_rsp1_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_div        <= 8'd0;
      r_gap        <= 8'd0;
      r_tx         <= 8'd0;
      r_rx         <= 8'd0;
      r_rsp0_data  <= 8'd0;
      r_rsp1_data  <= 8'd0;
      r_edge       <= 5'd0;
      r_owner      <= 1'b0;
      r_last       <= 1'b1;
      r_sck        <= 1'b0;
      r_ss         <= 1'b1;
      r_mosi       <= 1'b0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
    end else begin
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_tx    <= w_req_data;
            r_owner <= w_grant;
            r_last  <= w_grant;
            r_ss    <= 1'b0;
            r_mosi  <= w_req_data[7];
            r_div   <= 8'd0;
            r_edge  <= 5'd0;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (w_div_tc) begin
            r_div   <= 8'd0;
            r_sck   <= 1'b1;
            r_edge  <= 5'd1;
            r_state <= S_SHIFT;
          end else begin
            r_div <= r_div + 8'd1;
          end
        end
        S_SHIFT: begin
          if (w_div_tc) begin
            r_div <= 8'd0;
            r_sck <= ~r_sck;
            if (!r_sck) begin
              // Rising edge: the reply occupies edges 9..16.
              r_edge <= r_edge + 5'd1;
              if (r_edge >= 5'd8) begin
                r_rx <= {r_rx[6:0], bus.spi_miso};
              end
            end else if (r_edge == 5'd16) begin
              r_ss    <= 1'b1;
              r_mosi  <= 1'b0;
              r_state <= S_DONE;
              if (r_owner) begin
                r_rsp1_valid <= 1'b1;
                r_rsp1_data  <= r_rx;
              end else begin
                r_rsp0_valid <= 1'b1;
                r_rsp0_data  <= r_rx;
              end
            end else begin
              // Falling edge: present the next request bit, then idle low.
              r_mosi <= (r_edge < 5'd8) ? r_tx[6] : 1'b0;
              r_tx   <= {r_tx[6:0], 1'b0};
            end
          end else begin
            r_div <= r_div + 8'd1;
          end
        end
        S_DONE: begin
          r_gap   <= 8'd0;
          r_state <= S_GAP;
        end
        S_GAP: begin
          if (r_gap == c_gap_last) begin
            r_state <= S_IDLE;
          end else begin
            r_gap <= r_gap + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bitrev_spi_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_bitrev_spi_ctrl : scoreboard bench with a bit-reverse SPI peripheral      |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_bitrev_spi_ctrl;
  localparam int CLK_DIV = 2;
  localparam int SS_GAP  = 3;
  localparam int FRAME   = 32 * CLK_DIV;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bitrev_spi_ctrl_if bus ();

  bitrev_spi_ctrl #(.CLK_DIV(CLK_DIV), .SS_GAP(SS_GAP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic logic [7:0] bit_rev(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7 - i];
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Peripheral: samples mosi on sck rise, returns the reversed byte on later falls.
  logic [7:0] p_rx;
  logic [7:0] p_rev;
  int         p_cnt;
  logic       p_sck_q;
  logic       p_ss_q;
  always @(negedge clk) begin
    if (!rst_n) begin
      bus.spi_miso = 1'b0;
      p_cnt   = 0;
      p_sck_q = 1'b0;
      p_ss_q  = 1'b1;
    end else begin
      if (p_ss_q && !bus.spi_ss) p_cnt = 0;
      if (!bus.spi_ss && bus.spi_sck && !p_sck_q) begin
        if (p_cnt < 8) p_rx = {p_rx[6:0], bus.spi_mosi};
        p_cnt++;
      end
      if (!bus.spi_ss && !bus.spi_sck && p_sck_q) begin
        p_rev = bit_rev(p_rx);
        bus.spi_miso = (p_cnt >= 8 && p_cnt < 16) ? p_rev[15 - p_cnt] : 1'b0;
      end
      p_sck_q = bus.spi_sck;
      p_ss_q  = bus.spi_ss;
    end
  end

  // Scoreboard and pin monitor.
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  int         acc_q0[$];
  int         acc_q1[$];
  logic [7:0] tx_q[$];
  int         grant_log[$];
  int         acc_log[$];
  int         rises;
  int         ss_high;
  bit         seen_frame;
  logic [7:0] mosi_cap;
  logic       m_sck_q;
  logic       m_ss_q;
  logic       m_mosi_q;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q0.delete(); exp_q1.delete(); acc_q0.delete(); acc_q1.delete();
      tx_q.delete(); grant_log.delete(); acc_log.delete();
      rises = 0; ss_high = 0; seen_frame = 0;
      m_sck_q = 1'b0; m_ss_q = 1'b1; m_mosi_q = 1'b0;
    end else begin
      if (bus.req0_valid && bus.req0_ready) begin
        exp_q0.push_back(bit_rev(bus.req0_data)); acc_q0.push_back(cyc);
        tx_q.push_back(bus.req0_data); grant_log.push_back(0); acc_log.push_back(cyc);
      end
      if (bus.req1_valid && bus.req1_ready) begin
        exp_q1.push_back(bit_rev(bus.req1_data)); acc_q1.push_back(cyc);
        tx_q.push_back(bus.req1_data); grant_log.push_back(1); acc_log.push_back(cyc);
      end
      if ((bus.req0_valid || bus.req1_valid) && bus.busy)
        check_eq("ready_while_busy", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
      if (!bus.spi_ss && bus.spi_sck && !m_sck_q) begin
        rises++;
        if (rises <= 8) mosi_cap = {mosi_cap[6:0], bus.spi_mosi};
        check_eq("mosi_stable_at_rise", 32'(bus.spi_mosi), 32'(m_mosi_q));
      end
      if (bus.rsp0_valid || bus.rsp1_valid) begin
        check_eq("ss_high_at_rsp", 32'(bus.spi_ss), 32'd1);
        check_eq("sck_rise_count", 32'(rises), 32'd16);
        if (tx_q.size() > 0) check_eq("mosi_bits", 32'(mosi_cap), 32'(tx_q.pop_front()));
        rises = 0;
      end
      if (bus.rsp0_valid) begin
        if (exp_q0.size() == 0) check_eq("rsp0_unexpected", 32'd1, 32'd0);
        else begin
          check_eq("rsp0_data", 32'(bus.rsp0_data), 32'(exp_q0.pop_front()));
          check_eq("rsp0_latency", 32'(cyc - acc_q0.pop_front()), 32'(FRAME + 1));
        end
      end
      if (bus.rsp1_valid) begin
        if (exp_q1.size() == 0) check_eq("rsp1_unexpected", 32'd1, 32'd0);
        else begin
          check_eq("rsp1_data", 32'(bus.rsp1_data), 32'(exp_q1.pop_front()));
          check_eq("rsp1_latency", 32'(cyc - acc_q1.pop_front()), 32'(FRAME + 1));
        end
      end
      if (bus.spi_ss) ss_high++;
      if (!bus.spi_ss && m_ss_q) begin
        if (seen_frame) check_eq("ss_gap_min", 32'(ss_high >= SS_GAP), 32'd1);
        seen_frame = 1;
        ss_high = 0;
      end
      m_sck_q  = bus.spi_sck;
      m_ss_q   = bus.spi_ss;
      m_mosi_q = bus.spi_mosi;
    end
  end

  task automatic send(input int port, input logic [7:0] data);
    int n = 0;
    bit done = 0;
    @(posedge clk); #1;
    if (port == 0) begin bus.req0_valid = 1'b1; bus.req0_data = data; end
    else           begin bus.req1_valid = 1'b1; bus.req1_data = data; end
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
      if (port == 0 ? bus.req0_ready : bus.req1_ready) done = 1;
    end
    if (!done) check_eq("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    if (port == 0) bus.req0_valid = 1'b0; else bus.req1_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((bus.busy || exp_q0.size() != 0 || exp_q1.size() != 0) && n < 5000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 5000) check_eq("drain_timeout", 32'd0, 32'd1);
    repeat (2) @(posedge clk);
  endtask

  task automatic do_reset();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ss",    32'(bus.spi_ss),   32'd1);
    check_eq("rst_sck",   32'(bus.spi_sck),  32'd0);
    check_eq("rst_mosi",  32'(bus.spi_mosi), 32'd0);
    check_eq("rst_busy",  32'(bus.busy),     32'd0);
    check_eq("rst_rsp_v", 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'd0);
    check_eq("rst_rsp_d", 32'({bus.rsp1_data, bus.rsp0_data}), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seq_exp[4] = '{0, 1, 0, 1};
    int n;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.req0_data  = 8'h00; bus.req1_data  = 8'h00;
    do_reset();

    send(0, 8'h01); drain();
    send(1, 8'h12); drain();

    // Both ports requesting continuously from a fresh pointer.
    do_reset();
    fork
      begin send(0, 8'h0F); send(0, 8'h0F); end
      begin send(1, 8'hA5); send(1, 8'hA5); end
    join
    drain();
    check_eq("alt_count", 32'(grant_log.size()), 32'd4);
    if (grant_log.size() == 4)
      for (int i = 0; i < 4; i++) check_eq("alt_order", 32'(grant_log[i]), 32'(seq_exp[i]));

    // Back-to-back on one port lands on the earliest legal accept.
    acc_log.delete();
    send(0, 8'h3C); send(0, 8'hC1); drain();
    check_eq("b2b_count", 32'(acc_log.size()), 32'd2);
    if (acc_log.size() == 2)
      check_eq("b2b_spacing", 32'(acc_log[1] - acc_log[0]), 32'(FRAME + 2 + SS_GAP));

    // A request raised mid-frame is taken on the first IDLE cycle.
    acc_log.delete();
    fork
      send(0, 8'h5A);
      begin repeat (10) @(posedge clk); send(1, 8'h33); end
    join
    drain();
    check_eq("wait_count", 32'(acc_log.size()), 32'd2);
    if (acc_log.size() == 2)
      check_eq("wait_first_idle", 32'(acc_log[1] - acc_log[0]), 32'(FRAME + 2 + SS_GAP));

    // Abort a frame after rising edge 5.
    @(posedge clk); #1;
    bus.req0_data = 8'h55; bus.req0_valid = 1'b1;
    n = 0;
    while (rises < 5 && n < 1000) begin @(posedge clk); n++; end
    if (n >= 1000) check_eq("edge5_timeout", 32'd0, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("abort_ss",  32'(bus.spi_ss),  32'd1);
    check_eq("abort_sck", 32'(bus.spi_sck), 32'd0);
    check_eq("abort_rsp", 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("ready_after_release", 32'(bus.req0_ready), 32'd1);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    drain();

    check_eq("q0_empty", 32'(exp_q0.size()), 32'd0);
    check_eq("q1_empty", 32'(exp_q1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
